// File: rtl/ram_arbiter_if.sv
// Requester command/response, RAM control and status signals of ram_arbiter.
// Requesters and the RAM sit on the master side, and the arbiter sits on the slave side.
interface ram_arbiter_if #(
   parameter int data_width = 8,
   parameter int addr_width = 3
);
   logic                  req0;
   logic                  we0;
   logic [addr_width-1:0] addr0;
   logic [data_width-1:0] wdata0;
   logic                  ack0;
   logic [data_width-1:0] rdata0;

   logic                  req1;
   logic                  we1;
   logic [addr_width-1:0] addr1;
   logic [data_width-1:0] wdata1;
   logic                  ack1;
   logic [data_width-1:0] rdata1;

   logic                  ram_en;
   logic                  ram_we;
   logic [addr_width-1:0] ram_addr;
   logic [data_width-1:0] ram_di;
   logic [data_width-1:0] ram_do;
   logic                  busy;

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output ram_do,
      input  ack0, rdata0, ack1, rdata1,
      input  ram_en, ram_we, ram_addr, ram_di, busy
   );

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  ram_do,
      output ack0, rdata0, ack1, rdata1,
      output ram_en, ram_we, ram_addr, ram_di, busy
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two requesters onto a registered-output RAM.
// A request sampled in IDLE is acked 3 cycles later; the other requester waits holding its req.
module ram_arbiter #(
   parameter int data_width = 8,
   parameter int addr_width = 3
) (
   input  logic           i_clock,
   input  logic           i_reset,
   ram_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

   state_t                r_state;
   logic                  r_owner;
   logic                  r_last;
   logic                  r_ram_en;
   logic                  r_ram_we;
   logic [addr_width-1:0] r_ram_addr;
   logic [data_width-1:0] r_ram_di;
   logic [data_width-1:0] r_rdata0;
   logic [data_width-1:0] r_rdata1;
   logic                  r_ack0;
   logic                  r_ack1;

   logic                  w_elig0;
   logic                  w_elig1;
   logic                  w_grant1;

   // A requester acked this cycle still shows its old command, so it sits out.
   assign w_elig0  = bus.req0 & ~r_ack0;
   assign w_elig1  = bus.req1 & ~r_ack1;
   assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_ram_en   <= 1'b0;
         r_ram_we   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_di   <= '0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_elig0 | w_elig1) begin
                  r_state    <= ST_ISSUE;
                  r_owner    <= w_grant1;
                  r_ram_en   <= 1'b1;
                  r_ram_we   <= w_grant1 ? bus.we1    : bus.we0;
                  r_ram_addr <= w_grant1 ? bus.addr1  : bus.addr0;
                  r_ram_di   <= w_grant1 ? bus.wdata1 : bus.wdata0;
               end
            end
            ST_ISSUE: begin
               r_state  <= ST_DONE;
               r_ram_en <= 1'b0;
               r_ram_we <= 1'b0;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_last  <= r_owner;
               if (r_owner) begin
                  r_rdata1 <= bus.ram_do;
                  r_ack1   <= 1'b1;
               end else begin
                  r_rdata0 <= bus.ram_do;
                  r_ack0   <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_ram_en <= 1'b0;
               r_ram_we <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ram_en   = r_ram_en;
   assign bus.ram_we   = r_ram_we;
   assign bus.ram_addr = r_ram_addr;
   assign bus.ram_di   = r_ram_di;
   assign bus.ack0     = r_ack0;
   assign bus.ack1     = r_ack1;
   assign bus.rdata0   = r_rdata0;
   assign bus.rdata1   = r_rdata1;
   assign bus.busy     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural shift-in RAM and per-requester expected-data queues.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   logic [7:0] exp0_q[$];
   logic [7:0] exp1_q[$];
   logic [7:0] model_mem [8];

   logic [7:0] ram_mem [8] = '{default: 8'h00};
   logic [7:0] ram_do_r = 8'h00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_arbiter_if #(.data_width(8), .addr_width(3)) bus ();

   ram_arbiter #(.data_width(8), .addr_width(3)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // Shift-in RAM: writes push di into slot 0 and echo it; reads return the addressed slot.
   assign bus.ram_do = ram_do_r;
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            for (int i = 7; i > 0; i--) ram_mem[i] <= ram_mem[i-1];
            ram_mem[0] <= bus.ram_di;
            ram_do_r   <= bus.ram_di;
         end else begin
            ram_do_r <= ram_mem[bus.ram_addr];
         end
      end
   end

   function automatic void shift_model(input logic [7:0] d);
      for (int i = 7; i > 0; i--) model_mem[i] = model_mem[i-1];
      model_mem[0] = d;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if ({bus.ram_en, bus.ram_we, bus.ack0, bus.ack1, bus.busy} !== 5'b0)
            begin miscompares++; $display("FAIL reset_ctrl: got %b required 00000",
               {bus.ram_en, bus.ram_we, bus.ack0, bus.ack1, bus.busy}); end
         vectors++;
         if ({bus.ram_addr, bus.ram_di, bus.rdata0, bus.rdata1} !== 27'd0)
            begin miscompares++; $display("FAIL reset_data: got %h required 0",
               {bus.ram_addr, bus.ram_di, bus.rdata0, bus.rdata1}); end
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      logic [7:0] e;
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd5; bus.wdata0 = 8'hA5;
      shift_model(8'hA5);
      exp0_q.push_back(8'hA5);
      @(negedge clk);
      vectors++;
      if (bus.ram_en !== 1'b0) begin miscompares++; $display("FAIL wr_en_t0: got %b required 0", bus.ram_en); end
      @(negedge clk);
      vectors++;
      if ({bus.ram_en, bus.ram_we, bus.ram_di, bus.busy} !== {2'b11, 8'hA5, 1'b1})
         begin miscompares++; $display("FAIL wr_issue: got %h required %h",
            {bus.ram_en, bus.ram_we, bus.ram_di, bus.busy}, {2'b11, 8'hA5, 1'b1}); end
      @(negedge clk);
      vectors++;
      if ({bus.ram_en, bus.ram_we, bus.ack0} !== 3'b000)
         begin miscompares++; $display("FAIL wr_done: got %b required 000", {bus.ram_en, bus.ram_we, bus.ack0}); end
      @(negedge clk);
      e = exp0_q.pop_front();
      vectors++;
      if ({bus.ack0, bus.ack1} !== 2'b10) begin miscompares++; $display("FAIL wr_ack: got %b required 10", {bus.ack0, bus.ack1}); end
      vectors++;
      if (bus.rdata0 !== e) begin miscompares++; $display("FAIL wr_rdata0: got %h required %h", bus.rdata0, e); end
      @(posedge clk); #1;
      bus.req0 = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.ack0, bus.ram_en} !== 2'b00) begin miscompares++; $display("FAIL wr_after: got %b required 00", {bus.ack0, bus.ram_en}); end
   endtask

   task automatic test_read();
      logic [7:0] e;
      @(posedge clk); #1;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd0; bus.wdata1 = 8'hFF;
      exp1_q.push_back(model_mem[0]);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 3'd0})
         begin miscompares++; $display("FAIL rd_issue: got %b required 10000", {bus.ram_en, bus.ram_we, bus.ram_addr}); end
      @(negedge clk);
      @(negedge clk);
      e = exp1_q.pop_front();
      vectors++;
      if ({bus.ack0, bus.ack1} !== 2'b01) begin miscompares++; $display("FAIL rd_ack: got %b required 01", {bus.ack0, bus.ack1}); end
      vectors++;
      if (bus.rdata1 !== e) begin miscompares++; $display("FAIL rd_rdata1: got %h required %h", bus.rdata1, e); end
      vectors++;
      if (bus.rdata0 !== 8'hA5) begin miscompares++; $display("FAIL rd_rdata0_held: got %h required a5", bus.rdata0); end
      @(posedge clk); #1;
      bus.req1 = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [7:0] e;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd2; bus.wdata0 = 8'h11;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd0; bus.wdata1 = 8'h00;
      shift_model(8'h11);
      exp0_q.push_back(8'h11);
      exp1_q.push_back(model_mem[0]);
      repeat (4) @(negedge clk);
      e = exp0_q.pop_front();
      vectors++;
      if ({bus.ack0, bus.ack1, bus.busy, bus.ram_en} !== 4'b1000)
         begin miscompares++; $display("FAIL sim_ack0: got %b required 1000", {bus.ack0, bus.ack1, bus.busy, bus.ram_en}); end
      vectors++;
      if (bus.rdata0 !== e) begin miscompares++; $display("FAIL sim_rdata0: got %h required %h", bus.rdata0, e); end
      @(posedge clk); #1;
      bus.req0 = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 3'd0})
         begin miscompares++; $display("FAIL sim_issue1: got %b required 10000", {bus.ram_en, bus.ram_we, bus.ram_addr}); end
      @(negedge clk);
      @(negedge clk);
      e = exp1_q.pop_front();
      vectors++;
      if ({bus.ack0, bus.ack1} !== 2'b01) begin miscompares++; $display("FAIL sim_ack1: got %b required 01", {bus.ack0, bus.ack1}); end
      vectors++;
      if (bus.rdata1 !== e) begin miscompares++; $display("FAIL sim_rdata1: got %h required %h", bus.rdata1, e); end
      @(posedge clk); #1;
      bus.req1 = 1'b0;
   endtask

   task automatic test_back_to_back();
      int         done = 0;
      int         issued = 2;
      int         last = -1;
      int         last_cyc = -1;
      int         owner;
      logic [7:0] e;
      logic [7:0] got;
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.wdata0 = 8'h10; exp0_q.push_back(8'h10);
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.wdata1 = 8'h80; exp1_q.push_back(8'h80);
      for (int budget = 0; budget < 120 && done < 12; budget++) begin
         @(negedge clk);
         if (bus.ack0 && bus.ack1) begin
            vectors++; miscompares++;
            $display("FAIL b2b_both_ack: got 11 required one-hot");
         end else if (bus.ack0 || bus.ack1) begin
            owner = bus.ack1 ? 1 : 0;
            got   = owner ? bus.rdata1 : bus.rdata0;
            if ((owner ? exp1_q.size() : exp0_q.size()) == 0) begin
               vectors++; miscompares++;
               $display("FAIL b2b_unexpected_ack: got ack%0d required none", owner);
            end else begin
               e = owner ? exp1_q.pop_front() : exp0_q.pop_front();
               vectors++;
               if (got !== e) begin miscompares++; $display("FAIL b2b_rdata%0d: got %h required %h", owner, got, e); end
               shift_model(e);
            end
            vectors++;
            if (owner == last) begin miscompares++; $display("FAIL b2b_owner: got %0d twice required alternation", owner); end
            if (last_cyc >= 0) begin
               vectors++;
               if (cyc - last_cyc != 3) begin miscompares++; $display("FAIL b2b_spacing: got %0d required 3", cyc - last_cyc); end
            end
            last = owner;
            last_cyc = cyc;
            done++;
            @(posedge clk); #1;
            if (issued < 12) begin
               if (owner == 0) begin bus.wdata0 = 8'h10 + 8'(issued); exp0_q.push_back(bus.wdata0); end
               else begin bus.wdata1 = 8'h80 + 8'(issued); exp1_q.push_back(bus.wdata1); end
               issued++;
            end else if (owner == 0) bus.req0 = 1'b0;
            else bus.req1 = 1'b0;
         end
      end
      vectors++;
      if (done != 12) begin miscompares++; $display("FAIL b2b_count: got %0d required 12", done); end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic test_reset_mid_issue();
      logic [7:0] e;
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd1; bus.wdata0 = 8'h3C;
      exp0_q.push_back(8'h3C);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.ram_en !== 1'b1) begin miscompares++; $display("FAIL rst_issue_en: got %b required 1", bus.ram_en); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.ram_en, bus.ack0, bus.busy, bus.rdata0} !== 11'd0)
         begin miscompares++; $display("FAIL rst_abort: got %h required 0", {bus.ram_en, bus.ack0, bus.busy, bus.rdata0}); end
      @(negedge clk);
      vectors++;
      if ({bus.ram_en, bus.ram_we, bus.ram_di, bus.ack0} !== {2'b11, 8'h3C, 1'b0})
         begin miscompares++; $display("FAIL rst_reissue: got %h required %h",
            {bus.ram_en, bus.ram_we, bus.ram_di, bus.ack0}, {2'b11, 8'h3C, 1'b0}); end
      @(negedge clk);
      vectors++;
      if (bus.ack0 !== 1'b0) begin miscompares++; $display("FAIL rst_early_ack: got %b required 0", bus.ack0); end
      @(negedge clk);
      e = exp0_q.pop_front();
      vectors++;
      if (bus.ack0 !== 1'b1) begin miscompares++; $display("FAIL rst_ack0: got %b required 1", bus.ack0); end
      vectors++;
      if (bus.rdata0 !== e) begin miscompares++; $display("FAIL rst_rdata0: got %h required %h", bus.rdata0, e); end
      @(posedge clk); #1;
      bus.req0 = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 3'd0; bus.wdata0 = 8'h00;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 3'd0; bus.wdata1 = 8'h00;
      for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
      test_reset();
      test_single_write();
      test_read();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_issue();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
